// File: rtl/toymips_pkg.sv
// Shared types and constants for the toyMIPS front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package toymips_pkg;

  localparam int PC_W        = 8;
  localparam int INST_W      = 32;
  localparam int PC_STEP_DEF = 4;

  // Instruction word that an empty slot holds after reset.
  localparam logic [INST_W-1:0] NOP = 32'h0;

  // One fetched instruction together with the address it came from.
  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/ifetch_fifo.sv
// Skid FIFO of fetch entries between the instruction memory and decode.
// Latency: a push becomes visible at the head on the cycle after its edge (no bypass).
// Backpressure: none internally; the caller keeps push from hitting a full FIFO.
//
// Ports:
//   clk, rst        clock and asynchronous active-high reset
//   push, push_dat  write one entry at the tail
//   pop             release the head entry (ignored when empty)
//   flush           drop all entries; wins over push and pop
//   count           number of stored entries
//   empty           no entry stored
//   head            entry at the head (stable until popped)
module ifetch_fifo
  import toymips_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  fetch_entry_t  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [CW-1:0] count,
  output logic          empty,
  output fetch_entry_t  head
);

  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_pop;

  assign empty  = (count == '0);
  assign do_pop = pop & ~empty;
  assign head   = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '{pc: '0, inst: NOP};
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_dat;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // The issue logic reserves a slot for every request, so a push into a
  // full FIFO without a matching pop means that reservation was broken.
  a_no_overflow : assert property (
    @(posedge clk) disable iff (rst)
    (push && !flush && !do_pop) |-> (count != FULL)
  );

endmodule

// File: rtl/ifetch_stage.sv
// Instruction fetch: owns the PC, reads a synchronous imem, hands {inst, pc} to decode.
// Latency: request in cycle N -> inst_valid in cycle N+2; one instruction per cycle sustained.
// Backpressure: requests stop while FIFO occupancy plus the in-flight word would exceed DEPTH.
//
// Ports:
//   clk, rst                     clock and asynchronous active-high reset
//   redirect_valid, redirect_pc  load a new fetch PC and flush the stage
//   imem_req, imem_addr          read request to instruction memory (addr = PC)
//   imem_rdata                   read data, one cycle after imem_req
//   inst_valid, inst_ready       handshake with decode
//   inst, inst_pc                head instruction and its PC
module ifetch_stage
  import toymips_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC = 8'h00,
  parameter int              PC_STEP  = PC_STEP_DEF,
  parameter int              DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [PC_W-1:0]   inst_pc
);

  localparam int              CW      = $clog2(DEPTH + 1);
  localparam logic [PC_W-1:0] STEP    = PC_W'(PC_STEP);
  localparam logic [CW:0]     DEPTH_V = (CW + 1)'(DEPTH);

  logic [PC_W-1:0] pc;
  logic [PC_W-1:0] req_pc;
  logic            inflight;
  logic            issue;
  logic            pop;
  logic            push;
  logic            fifo_empty;
  logic [CW-1:0]   count;
  logic [CW:0]     occ;
  fetch_entry_t    resp;
  fetch_entry_t    head;

  assign inst_valid = ~fifo_empty;
  assign pop        = inst_valid & inst_ready;

  // Slots already claimed once this cycle's pop is taken: stored entries
  // plus the word still coming back from memory.
  assign occ   = {1'b0, count} + (CW + 1)'(inflight) - (CW + 1)'(pop);
  assign issue = ~redirect_valid & (occ < DEPTH_V);

  // Reset state alone would still allow an issue, so the request is masked
  // explicitly while rst is held.
  assign imem_req  = issue & ~rst;
  assign imem_addr = pc;

  // A redirect in the response cycle kills the returning word.
  assign push = inflight & ~redirect_valid;
  assign resp = '{pc: req_pc, inst: imem_rdata};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= RESET_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        pc     <= pc + STEP;
        req_pc <= pc;
      end
    end
  end

  ifetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_dat (resp),
    .pop      (pop),
    .flush    (redirect_valid),
    .count    (count),
    .empty    (fifo_empty),
    .head     (head)
  );

  assign inst    = head.inst;
  assign inst_pc = head.pc;

endmodule
